// File: rtl/load_store_unit_if.sv
// Request/response/memory bus bundle for load_store_unit.
// The slave modport is the LSU's view: it receives requests from the execute
// stage, returns responses and drives the word-wide data memory.
// The master modport is the surrounding system's view of the same wires.
interface load_store_unit_if #(
    parameter int A_WIDTH = 20,
    parameter int D_WIDTH = 32
) ();
    // execute-stage request
    logic               req_valid;
    logic               req_ready;
    logic               req_store;
    logic [2:0]         req_funct3;
    logic [A_WIDTH+1:0] req_addr;
    logic [D_WIDTH-1:0] req_wdata;
    // response back to the pipeline
    logic               resp_valid;
    logic               resp_ready;
    logic [D_WIDTH-1:0] resp_rdata;
    logic               resp_err;
    // data memory port (async read, sync write)
    logic [A_WIDTH-1:0] mem_a;
    logic [D_WIDTH-1:0] mem_wd;
    logic               mem_we;
    logic [D_WIDTH-1:0] mem_rd;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_a, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine for a word-wide data
// memory. Byte addresses become word indices; SB/SH are done as
// read-modify-write, LB/LH/LBU/LHU are extracted and sign/zero extended.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses return
// an error response instead of being aligned down.
module load_store_unit #(
    parameter int A_WIDTH = 20,
    parameter int D_WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    load_store_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // request fields held for the duration of the operation
    logic [1:0]         r_addr_lo;
    logic [2:0]         r_funct3;
    logic               r_store;
    logic [15:0]        r_wdata_lo;

    // registered outputs
    logic [A_WIDTH-1:0] r_mem_a;
    logic [D_WIDTH-1:0] r_mem_wd;
    logic [D_WIDTH-1:0] r_rdata;
    logic               r_err;

    logic               w_accept;
    logic               w_illegal;
    logic               w_misalign;
    logic               w_err;
    logic               w_is_sw;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [D_WIDTH-1:0] w_load_data;
    logic [D_WIDTH-1:0] w_merged;
    logic [3:0]         w_lane_sel;

    assign w_accept = bus.req_valid & (r_state == S_IDLE);
    assign w_is_sw  = bus.req_store & (bus.req_funct3 == 3'b010);
    assign w_err    = w_illegal | w_misalign;

    // decode illegal funct3 values for the incoming request
    always_comb begin
        w_illegal = 1'b0;
        if (bus.req_store) begin
            w_illegal = bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (bus.req_funct3[1:0] == 2'b11) | (bus.req_funct3 == 3'b110);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // halfwords need addr[0]=0, words need addr[1:0]=0
    always_comb begin
        w_misalign = 1'b0;
        if (bus.req_funct3[1:0] == 2'b01) begin
            w_misalign = bus.req_addr[0];
        end else if (bus.req_funct3[1:0] == 2'b10) begin
            w_misalign = (bus.req_addr[1:0] != 2'b00);
        end
    end
`else
    // misaligned accesses are silently aligned down
    assign w_misalign = 1'b0;
`endif

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_next = S_RESP;
                    end else if (w_is_sw) begin
                        w_state_next = S_WRITE;
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            S_READ:  w_state_next = r_store ? S_WRITE : S_RESP;
            S_WRITE: w_state_next = S_RESP;
            S_RESP:  w_state_next = bus.resp_ready ? S_IDLE : S_RESP;
            default: w_state_next = S_IDLE;
        endcase
    end

    // select the addressed byte/half of the word currently read from memory
    always_comb begin
        w_byte = bus.mem_rd[7:0];
        case (r_addr_lo)
            2'd0: w_byte = bus.mem_rd[7:0];
            2'd1: w_byte = bus.mem_rd[15:8];
            2'd2: w_byte = bus.mem_rd[23:16];
            2'd3: w_byte = bus.mem_rd[31:24];
            default: w_byte = bus.mem_rd[7:0];
        endcase
        w_half = r_addr_lo[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    end

    // extend the selected field according to the load type
    always_comb begin
        w_load_data = bus.mem_rd;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = bus.mem_rd;
        endcase
    end

    // per-lane merge for SB/SH: replaced lanes take store data, others keep memory
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = gi[1:0];
        assign w_lane_sel[gi] = (r_funct3[1:0] == 2'b00) ? (r_addr_lo == LANE)
                                                         : (r_addr_lo[1] == LANE[1]);
        assign w_merged[8*gi +: 8] =
            !w_lane_sel[gi]                       ? bus.mem_rd[8*gi +: 8] :
            (r_funct3[1:0] == 2'b00 || !LANE[0]) ? r_wdata_lo[7:0]        :
                                                    r_wdata_lo[15:8];
    end

    // request capture, memory address/data and response registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr_lo  <= '0;
            r_funct3   <= '0;
            r_store    <= 1'b0;
            r_wdata_lo <= '0;
            r_mem_a    <= '0;
            r_mem_wd   <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr_lo  <= bus.req_addr[1:0];
                        r_funct3   <= bus.req_funct3;
                        r_store    <= bus.req_store;
                        r_wdata_lo <= bus.req_wdata[15:0];
                        r_rdata    <= '0;
                        r_err      <= w_err;
                        if (!w_err) begin
                            r_mem_a <= bus.req_addr[A_WIDTH+1:2];
                            if (w_is_sw) begin
                                r_mem_wd <= bus.req_wdata;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (r_store) begin
                        r_mem_wd <= w_merged;
                    end else begin
                        r_rdata <= w_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.mem_a      = r_mem_a;
    assign bus.mem_wd     = r_mem_wd;
    // a write never happens in a cycle where reset is asserted
    assign bus.mem_we     = (r_state == S_WRITE) & ~i_rst;

endmodule
